// File: rtl/hockey_pkg.sv
// hockey_pkg: shared encodings and types for the hockey turn controller.
package hockey_pkg;

   localparam int COORD_W = 3;
   localparam logic [COORD_W-1:0] FIELD_MAX = 3'd4;

   // Shot directions; code 3 is folded to straight on load.
   localparam logic [1:0] DIR_STRAIGHT = 2'd0;
   localparam logic [1:0] DIR_UP       = 2'd1;
   localparam logic [1:0] DIR_DOWN     = 2'd2;

   // FSM encodings, also exported on the debug state port.
   localparam logic [2:0] S_SERVE_A = 3'd0;
   localparam logic [2:0] S_SERVE_B = 3'd1;
   localparam logic [2:0] S_MOVE_B  = 3'd2;
   localparam logic [2:0] S_WAIT_B  = 3'd3;
   localparam logic [2:0] S_MOVE_A  = 3'd4;
   localparam logic [2:0] S_WAIT_A  = 3'd5;
   localparam logic [2:0] S_OVER    = 3'd6;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [1:0]         dir;
   } ball_t;

   function automatic logic [1:0] norm_dir(input logic [1:0] d);
      return (d == 2'd3) ? DIR_STRAIGHT : d;
   endfunction

endpackage

// File: rtl/hockey_ball_step.sv
// hockey_ball_step: ball x/y/dir register with load and single-step update
// including wall bounce.
module hockey_ball_step
   import hockey_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  ball_t load_val,
   input  logic  step,
   input  logic  step_inc,
   output ball_t ball
);

   logic [1:0] dir_eff;

   // Bounce: a ball on a wall heading into it reverses before the step is applied.
   always_comb begin
      dir_eff = ball.dir;
      if (ball.dir == DIR_UP && ball.y == FIELD_MAX)
         dir_eff = DIR_DOWN;
      else if (ball.dir == DIR_DOWN && ball.y == '0)
         dir_eff = DIR_UP;
   end

   // Ball register: load takes priority over a step.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ball <= '0;
      end else if (load) begin
         ball <= load_val;
      end else if (step) begin
         ball.x   <= step_inc ? ball.x + 3'd1 : ball.x - 3'd1;
         ball.dir <= dir_eff;
         case (dir_eff)
            DIR_UP:   ball.y <= ball.y + 3'd1;
            DIR_DOWN: ball.y <= ball.y - 3'd1;
            default:  ;
         endcase
      end
   end

endmodule

// File: rtl/hockey_turn_ctrl.sv
// hockey_turn_ctrl: serve/return FSM, step and response timers, button edge
// detect and scoring around the shared ball datapath.
module hockey_turn_ctrl
   import hockey_pkg::*;
#(
   parameter int STEP_DIV  = 4,
   parameter int RESP_WIN  = 8,
   parameter int WIN_SCORE = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_a,
   input  logic               btn_b,
   input  logic [1:0]         dir_a,
   input  logic [1:0]         dir_b,
   input  logic [COORD_W-1:0] y_in_a,
   input  logic [COORD_W-1:0] y_in_b,
   output logic [COORD_W-1:0] x_coord,
   output logic [COORD_W-1:0] y_coord,
   output logic               turn,
   output logic [1:0]         score_a,
   output logic [1:0]         score_b,
   output logic               goal_a,
   output logic               goal_b,
   output logic               game_over,
   output logic               winner,
   output logic [2:0]         state
);

   localparam int SW = $clog2(STEP_DIV + 1);
   localparam int WW = $clog2(RESP_WIN + 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
   localparam logic [WW-1:0] WIN_LAST  = WW'(RESP_WIN - 1);
   localparam logic [1:0]    WIN_S     = 2'(WIN_SCORE);

   logic          btn_a_s, btn_a_p, btn_b_s, btn_b_p;
   logic          press_a, press_b;
   logic [2:0]    nxt;
   logic [SW-1:0] step_cnt;
   logic [WW-1:0] win_cnt;
   logic          in_move, in_wait, step_tick, win_last;
   logic          ld, stp, stp_inc, miss_a, miss_b;
   ball_t         ld_val, ball;

   // Button sample + previous sample; a press is the registered rising edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_a_s <= 1'b0;
         btn_a_p <= 1'b0;
         btn_b_s <= 1'b0;
         btn_b_p <= 1'b0;
      end else begin
         btn_a_s <= btn_a;
         btn_a_p <= btn_a_s;
         btn_b_s <= btn_b;
         btn_b_p <= btn_b_s;
      end
   end

   assign press_a   = btn_a_s & ~btn_a_p;
   assign press_b   = btn_b_s & ~btn_b_p;
   assign in_move   = (state == S_MOVE_A) || (state == S_MOVE_B);
   assign in_wait   = (state == S_WAIT_A) || (state == S_WAIT_B);
   assign step_tick = (step_cnt == STEP_LAST);
   assign win_last  = (win_cnt == WIN_LAST);

   hockey_ball_step u_ball (
      .clk      (clk),
      .rst      (rst),
      .load     (ld),
      .load_val (ld_val),
      .step     (stp),
      .step_inc (stp_inc),
      .ball     (ball)
   );

   // Next state, ball commands and miss detection; only the acting player is heard.
   always_comb begin
      nxt     = state;
      ld      = 1'b0;
      ld_val  = ball;
      stp     = 1'b0;
      stp_inc = 1'b0;
      miss_a  = 1'b0;
      miss_b  = 1'b0;
      case (state)
         S_SERVE_A: if (press_a && y_in_a <= FIELD_MAX) begin
            ld         = 1'b1;
            ld_val.x   = '0;
            ld_val.y   = y_in_a;
            ld_val.dir = norm_dir(dir_a);
            nxt        = S_MOVE_B;
         end
         S_SERVE_B: if (press_b && y_in_b <= FIELD_MAX) begin
            ld         = 1'b1;
            ld_val.x   = FIELD_MAX;
            ld_val.y   = y_in_b;
            ld_val.dir = norm_dir(dir_b);
            nxt        = S_MOVE_A;
         end
         S_MOVE_B: if (step_tick) begin
            stp     = 1'b1;
            stp_inc = 1'b1;
            if (ball.x == FIELD_MAX - 3'd1) nxt = S_WAIT_B;
         end
         S_MOVE_A: if (step_tick) begin
            stp = 1'b1;
            if (ball.x == 3'd1) nxt = S_WAIT_A;
         end
         S_WAIT_B: begin
            if (press_b && y_in_b == ball.y) begin
               ld         = 1'b1;
               ld_val.dir = norm_dir(dir_b);
               nxt        = S_MOVE_A;
            end else if (press_b || win_last) begin
               miss_b = 1'b1;
            end
         end
         S_WAIT_A: begin
            if (press_a && y_in_a == ball.y) begin
               ld         = 1'b1;
               ld_val.dir = norm_dir(dir_a);
               nxt        = S_MOVE_B;
            end else if (press_a || win_last) begin
               miss_a = 1'b1;
            end
         end
         default: ;
      endcase
      if (miss_b) nxt = (score_a + 2'd1 == WIN_S) ? S_OVER : S_SERVE_B;
      if (miss_a) nxt = (score_b + 2'd1 == WIN_S) ? S_OVER : S_SERVE_A;
   end

   // State, timers restarting on every state change, scores and goal pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_SERVE_A;
         step_cnt <= '0;
         win_cnt  <= '0;
         score_a  <= '0;
         score_b  <= '0;
         goal_a   <= 1'b0;
         goal_b   <= 1'b0;
         winner   <= 1'b0;
      end else begin
         state    <= nxt;
         step_cnt <= (in_move && nxt == state && !step_tick) ? step_cnt + 1'b1 : '0;
         win_cnt  <= (in_wait && nxt == state) ? win_cnt + 1'b1 : '0;
         goal_a   <= miss_b;
         goal_b   <= miss_a;
         if (miss_b) score_a <= score_a + 2'd1;
         if (miss_a) score_b <= score_b + 2'd1;
         if (nxt == S_OVER && state != S_OVER) winner <= miss_a;
      end
   end

   // Turn: who acts next, or the receiver while the ball is travelling.
   always_comb begin
      case (state)
         S_SERVE_B, S_MOVE_B, S_WAIT_B: turn = 1'b1;
         default:                       turn = 1'b0;
      endcase
   end

   assign x_coord   = ball.x;
   assign y_coord   = ball.y;
   assign game_over = (state == S_OVER);

endmodule

// File: tb/tb_hockey_turn_ctrl.sv
// tb_hockey_turn_ctrl: directed and randomized rallies checked against a
// rally-level game model (reflection-folded ball path, score tally).
module tb_hockey_turn_ctrl;

   localparam int STEP_DIV  = 4;
   localparam int RESP_WIN  = 8;
   localparam int WIN_SCORE = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_a = 1'b0, btn_b = 1'b0;
   logic [1:0] dir_a = '0, dir_b = '0;
   logic [2:0] y_in_a = '0, y_in_b = '0;
   logic [2:0] x_coord, y_coord, state;
   logic       turn, goal_a, goal_b, game_over, winner;
   logic [1:0] score_a, score_b;

   int checks = 0;
   int errors = 0;

   // Game model: ball position, vertical slope, scores.
   int m_x, m_y, m_s, m_sa, m_sb;
   bit m_over;

   always #5 clk = ~clk;

   hockey_turn_ctrl #(.STEP_DIV(STEP_DIV), .RESP_WIN(RESP_WIN), .WIN_SCORE(WIN_SCORE)) dut (
      .clk(clk), .rst(rst), .btn_a(btn_a), .btn_b(btn_b), .dir_a(dir_a), .dir_b(dir_b),
      .y_in_a(y_in_a), .y_in_b(y_in_b), .x_coord(x_coord), .y_coord(y_coord), .turn(turn),
      .score_a(score_a), .score_b(score_b), .goal_a(goal_a), .goal_b(goal_b),
      .game_over(game_over), .winner(winner), .state(state)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "bench did not finish");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Bouncing between walls 0 and 4 is a triangle wave of period 8 on the unfolded row.
   function automatic int fold(input int u);
      int m;
      m = ((u % 8) + 8) % 8;
      return (m <= 4) ? m : 8 - m;
   endfunction

   function automatic int sgn(input int d);
      return (d == 1) ? 1 : (d == 2) ? -1 : 0;
   endfunction

   task automatic model_reset();
      m_x = 0; m_y = 0; m_s = 0; m_sa = 0; m_sb = 0; m_over = 1'b0;
   endtask

   task automatic do_reset();
      btn_a = 1'b0; btn_b = 1'b0;
      rst = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(1);
      model_reset();
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_state"}, state, 0);
      chk({tag, "_x"}, x_coord, 0);
      chk({tag, "_y"}, y_coord, 0);
      chk({tag, "_turn"}, turn, 0);
      chk({tag, "_score_a"}, score_a, 0);
      chk({tag, "_score_b"}, score_b, 0);
      chk({tag, "_goals"}, {goal_a, goal_b}, 0);
      chk({tag, "_over"}, {game_over, winner}, 0);
   endtask

   // Release both buttons for a cycle, then raise the requested ones; returns
   // just after the edge on which the press takes effect.
   task automatic press(input bit pa, input bit pb, input int ya, input int yb,
                        input int da, input int db);
      btn_a = 1'b0; btn_b = 1'b0;
      tick(1);
      y_in_a = 3'(ya); y_in_b = 3'(yb); dir_a = 2'(da); dir_b = 2'(db);
      btn_a = pa; btn_b = pb;
      tick(2);
   endtask

   // Ball crossing toward receiver r; optionally the receiver presses mid-flight.
   task automatic fly(input int r, input bit poke);
      int x0, y0;
      x0 = m_x; y0 = m_y;
      for (int k = 1; k <= 4; k++) begin
         if (poke && k == 2) begin
            if (r == 1) btn_b = 1'b1; else btn_a = 1'b1;
         end
         tick(STEP_DIV - 1);
         chk("move_state", state, (r == 1) ? 2 : 4);
         tick(1);
         m_x = (r == 1) ? x0 + k : x0 - k;
         m_y = fold(y0 + m_s * k);
         chk("step_x", x_coord, m_x);
         chk("step_y", y_coord, m_y);
      end
      chk("wait_state", state, (r == 1) ? 3 : 5);
      chk("wait_turn", turn, r);
   endtask

   task automatic do_serve(input int p, input int y, input int d, input bit poke);
      press(p == 0, p == 1, y, y, d, d);
      m_x = (p == 1) ? 4 : 0; m_y = y; m_s = sgn(d);
      chk("serve_state", state, (p == 1) ? 4 : 2);
      chk("serve_turn", turn, 1 - p);
      chk("serve_x", x_coord, m_x);
      chk("serve_y", y_coord, m_y);
      fly(1 - p, poke);
   endtask

   // Receiver r returns the ball; with 'both' the opponent presses on the same cycle.
   task automatic do_hit(input int r, input int d, input bit both);
      int oy, od;
      oy = int'($urandom_range(0, 7)); od = int'($urandom_range(0, 3));
      if (r == 1) press(both, 1'b1, oy, m_y, od, d);
      else        press(1'b1, both, m_y, oy, d, od);
      m_s = sgn(d);
      chk("hit_state", state, (r == 1) ? 4 : 2);
      chk("hit_turn", turn, 1 - r);
      chk("hit_x", x_coord, m_x);
      chk("hit_y", y_coord, m_y);
      fly(1 - r, 1'b0);
   endtask

   // Receiver r misses, either by a wrong-row press or by letting the window lapse.
   task automatic do_miss(input int r, input bit timeout);
      int wy;
      if (timeout) begin
         tick(RESP_WIN - 1);
         chk("win_open_state", state, (r == 1) ? 3 : 5);
         chk("win_open_goal", {goal_a, goal_b}, 0);
         tick(1);
      end else begin
         do wy = int'($urandom_range(0, 7)); while (wy == m_y);
         if (r == 1) press(1'b0, 1'b1, 0, wy, 0, 0);
         else        press(1'b1, 1'b0, wy, 0, 0, 0);
      end
      if (r == 1) m_sa++; else m_sb++;
      m_over = (m_sa == WIN_SCORE) || (m_sb == WIN_SCORE);
      chk("goal_a_pulse", goal_a, r == 1);
      chk("goal_b_pulse", goal_b, r == 0);
      chk("score_a", score_a, m_sa);
      chk("score_b", score_b, m_sb);
      chk("miss_state", state, m_over ? 6 : ((r == 1) ? 1 : 0));
      chk("hold_x", x_coord, m_x);
      chk("hold_y", y_coord, m_y);
      tick(1);
      chk("goal_clear", {goal_a, goal_b}, 0);
      if (m_over) begin
         chk("game_over", game_over, 1);
         chk("winner", winner, 1 - r);
      end
   endtask

   task automatic check_over_frozen();
      int sa, sb, w;
      sa = m_sa; sb = m_sb; w = (m_sa == WIN_SCORE) ? 0 : 1;
      press(1'b1, 1'b1, 2, 2, 0, 0);
      tick(RESP_WIN + 2);
      chk("over_state", state, 6);
      chk("over_scores", {score_a, score_b}, {sa[1:0], sb[1:0]});
      chk("over_flag", game_over, 1);
      chk("over_winner", winner, w);
   endtask

   task automatic random_game();
      int server, r, rally;
      server = 0;
      while (!m_over) begin
         if ($urandom_range(0, 3) == 0) begin
            press(server == 0, server == 1, int'($urandom_range(5, 7)),
                  int'($urandom_range(5, 7)), 0, 0);
            chk("bad_serve_state", state, server);
            chk("bad_serve_x", x_coord, m_x);
         end
         do_serve(server, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 1)));
         r = 1 - server;
         rally = 0;
         while (rally < 5 && $urandom_range(0, 2) != 0) begin
            do_hit(r, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
            r = 1 - r;
            rally++;
         end
         do_miss(r, bit'($urandom_range(0, 1)));
         server = r;
      end
      check_over_frozen();
   endtask

   initial begin
      model_reset();
      tick(2);
      rst = 1'b1;
      tick(1);
      check_reset("reset");

      // Serve on an invalid row is ignored.
      press(1'b1, 1'b0, 5, 0, 0, 0);
      chk("inv_serve_state", state, 0);
      chk("inv_serve_x", x_coord, 0);

      // A serves straight from row 2; B presses during MOVE_B and is ignored.
      do_serve(0, 2, 0, 1'b1);
      chk("arrive_x", x_coord, 4);
      chk("arrive_y", y_coord, 2);

      // B returns upward: (3,3),(2,4),(1,3),(0,2).
      do_hit(1, 1, 1'b0);
      chk("bounce_end_x", x_coord, 0);
      chk("bounce_end_y", y_coord, 2);

      // A returns straight with B pressing simultaneously, then B misses on row.
      do_hit(0, 0, 1'b1);
      do_miss(1, 1'b0);

      // B serves; A holds the button from mid-flight, window lapses, B scores.
      do_serve(1, 2, 0, 1'b1);
      do_miss(0, 1'b1);
      tick(4);
      chk("held_no_serve", state, 0);

      // A wins 3-1.
      do_serve(0, 1, 2, 1'b0);
      do_miss(1, 1'b0);
      do_serve(1, 3, 3, 1'b0);
      do_hit(0, 1, 1'b0);
      do_miss(1, 1'b1);
      chk("a_wins_winner", winner, 0);
      check_over_frozen();

      // Reset asserted in the middle of a crossing, with a score on the board.
      do_reset();
      do_serve(0, 4, 1, 1'b0);
      do_miss(1, 1'b0);
      press(1'b0, 1'b1, 0, 3, 0, 2);
      tick(STEP_DIV + 1);
      btn_a = 1'b0; btn_b = 1'b0;
      rst = 1'b0;
      #1;
      check_reset("mid_reset");
      tick(1);
      rst = 1'b1;
      tick(2 * STEP_DIV);
      chk("post_reset_state", state, 0);
      chk("post_reset_x", x_coord, 0);
      model_reset();

      for (int g = 0; g < 3; g++) begin
         do_reset();
         chk("game_start_state", state, 0);
         random_game();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
